// File: rtl/dram_line_ctrl.sv
// dram_line_ctrl: cache-line refill/write-back engine issuing LINE_WORDS single-word DRAM beats.
// Define DRAM_LINE_CRIT_WORD_EN for critical-word-first beat order (wrapping within the line).
module dram_line_ctrl #(
  parameter int DATA_WDT   = 64,
  parameter int LINE_WORDS = 4,
  parameter int OFS_W      = $clog2(LINE_WORDS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_wr,
  input  logic [31:0]                    req_addr,
  input  logic [DATA_WDT*LINE_WORDS-1:0] wr_line,
  output logic [DATA_WDT*LINE_WORDS-1:0] rd_line,
  output logic                           done,
  output logic                           mem_en,
  output logic                           rd_wr,
  output logic [31:0]                    addr,
  output logic [DATA_WDT-1:0]            data_in,
  input  logic [DATA_WDT-1:0]            data_out,
  input  logic                           mem_valid
);
`ifdef DRAM_LINE_CRIT_WORD_EN
  localparam logic CRIT = 1'b1;
`else
  localparam logic CRIT = 1'b0;
`endif
  localparam logic [OFS_W:0] NW = (OFS_W+1)'(LINE_WORDS);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic wr_q;
  logic [31-OFS_W:0] base_hi;
  logic [OFS_W-1:0] start, req_ofs, beat_ofs, resp_ofs;
  logic [OFS_W:0] issue_cnt, resp_cnt;
  logic [DATA_WDT*LINE_WORDS-1:0] line_q;
  assign req_ready = state == IDLE;
  assign req_ofs   = CRIT ? req_addr[OFS_W-1:0] : '0;
  // offsets wrap naturally in OFS_W bits, so beats never leave the line
  assign beat_ofs  = start + issue_cnt[OFS_W-1:0];
  assign resp_ofs  = start + resp_cnt[OFS_W-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      base_hi   <= '0;
      start     <= '0;
      issue_cnt <= '0;
      resp_cnt  <= '0;
      line_q    <= '0;
      rd_line   <= '0;
      done      <= 1'b0;
      mem_en    <= 1'b0;
      rd_wr     <= 1'b0;
      addr      <= '0;
      data_in   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          state     <= ISSUE;
          wr_q      <= req_wr;
          base_hi   <= req_addr[31:OFS_W];
          start     <= req_ofs;
          line_q    <= wr_line;
          issue_cnt <= (OFS_W+1)'(1);
          resp_cnt  <= '0;
          mem_en    <= 1'b1;
          rd_wr     <= req_wr;
          addr      <= {req_addr[31:OFS_W], req_ofs};
          data_in   <= req_wr ? wr_line[req_ofs*DATA_WDT +: DATA_WDT] : '0;
        end
        ISSUE, WAIT: begin
          if (state == ISSUE) begin
            if (issue_cnt == NW) begin
              state  <= WAIT;
              mem_en <= 1'b0;
            end else begin
              addr      <= {base_hi, beat_ofs};
              data_in   <= wr_q ? line_q[beat_ofs*DATA_WDT +: DATA_WDT] : '0;
              issue_cnt <= issue_cnt + 1'b1;
            end
          end
          // responses return in issue order, so resp_cnt names the beat being answered
          if (mem_valid) begin
            if (!wr_q) rd_line[resp_ofs*DATA_WDT +: DATA_WDT] <= data_out;
            resp_cnt <= resp_cnt + 1'b1;
            if (resp_cnt == NW - 1'b1) begin
              state  <= RESP;
              done   <= 1'b1;
              mem_en <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
